// File: rtl/mu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mu_arb_pkg
// Brief    : Shared constants and types for the two-master MemoryUnit arbiter
// Revision : 1.0 - initial release
// ============================================================================
package mu_arb_pkg;

    // Default bus geometry of the MemoryUnit
    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 32;

    // Master indices: the CPU and the auxiliary master (e.g. DMA)
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    // Arbiter FSM encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_WAIT_HI = 2'd1;
    localparam arb_state_t ST_WAIT_LO = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mu_arb_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : mu_arb_req_latch
// Brief    : Per-master request latch: captures one request, holds it while
//            it is outstanding, and returns the registered read result
// Revision : 1.0 - initial release
// ============================================================================
module mu_arb_req_latch
    import mu_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_complete,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_q
);

    logic              r_pending;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [DATA_W-1:0] r_q;

    // Capture a request only into an empty latch; completion empties it.
    // i_complete is only raised for a pending latch, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_address <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
        end else if (i_start && !r_pending) begin
            r_pending <= 1'b1;
            r_address <= i_address;
            r_data    <= i_data;
            r_we      <= i_we;
        end else if (i_complete) begin
            r_pending <= 1'b0;
        end
    end

    // Read result register: updated only when a read completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_complete && !r_we) begin
            r_q <= i_rd_data;
        end
    end

    assign o_address = r_address;
    assign o_data    = r_data;
    assign o_we      = r_we;
    assign o_busy    = r_pending;
    assign o_q       = r_q;

endmodule
`default_nettype wire

// File: rtl/mu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mu_arbiter
// Brief    : Two-master arbiter in front of MemoryUnit. Each master sees the
//            MemoryUnit start/busy/q protocol; requests are latched, granted
//            round-robin or fixed-priority, and issued one at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mu_arbiter
    import mu_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_data,
    input  logic              m0_we,
    input  logic              m0_start,
    output logic              m0_busy,
    output logic [DATA_W-1:0] m0_q,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_data,
    input  logic              m1_we,
    input  logic              m1_start,
    output logic              m1_busy,
    output logic [DATA_W-1:0] m1_q,
    output logic [ADDR_W-1:0] mu_address,
    output logic [DATA_W-1:0] mu_data,
    output logic              mu_we,
    output logic              mu_start,
    input  logic              mu_busy,
    input  logic [DATA_W-1:0] mu_q,
    input  logic              mu_init_done
);

    localparam int C_NUM_M = 2;

    logic [C_NUM_M-1:0] w_req_start;
    logic [C_NUM_M-1:0] w_req_we;
    logic [ADDR_W-1:0]  w_req_address [C_NUM_M];
    logic [DATA_W-1:0]  w_req_data    [C_NUM_M];
    logic [ADDR_W-1:0]  w_lat_address [C_NUM_M];
    logic [DATA_W-1:0]  w_lat_data    [C_NUM_M];
    logic [C_NUM_M-1:0] w_lat_we;
    logic [C_NUM_M-1:0] w_pend;
    logic [C_NUM_M-1:0] w_complete;
    logic [DATA_W-1:0]  w_q           [C_NUM_M];

    arb_state_t         r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic [ADDR_W-1:0]  r_mu_address;
    logic [DATA_W-1:0]  r_mu_data;
    logic               r_mu_we;

    logic               w_winner;
    logic               w_issue;
    logic               w_done;

    assign w_req_start          = {m1_start, m0_start};
    assign w_req_we             = {m1_we, m0_we};
    assign w_req_address[M_CPU] = m0_address;
    assign w_req_address[M_AUX] = m1_address;
    assign w_req_data[M_CPU]    = m0_data;
    assign w_req_data[M_AUX]    = m1_data;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_M; gi++) begin : g_req
            mu_arb_req_latch #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_latch (
                .clk        (clk),
                .rst        (reset),
                .i_start    (w_req_start[gi]),
                .i_address  (w_req_address[gi]),
                .i_data     (w_req_data[gi]),
                .i_we       (w_req_we[gi]),
                .i_complete (w_complete[gi]),
                .i_rd_data  (mu_q),
                .o_address  (w_lat_address[gi]),
                .o_data     (w_lat_data[gi]),
                .o_we       (w_lat_we[gi]),
                .o_busy     (w_pend[gi]),
                .o_q        (w_q[gi])
            );

            assign w_complete[gi] = w_done && (r_grant == 1'(gi));
        end
    endgenerate

    // Winner selection: a lone requester always wins; ties go to the master
    // that was not served last, or to the CPU when priority is fixed.
    always_comb begin
        w_winner = w_pend[M_CPU] ? M_CPU : M_AUX;
        if (&w_pend) begin
            w_winner = (FIXED_PRIO != 0) ? M_CPU : ~r_last_grant;
        end
    end

    // Issue is combinational so mu_start appears in the cycle the latch fills
    assign w_issue = (r_state == ST_IDLE) && mu_init_done && (|w_pend);
    assign w_done  = (r_state == ST_WAIT_LO) && !mu_busy;

    // Transaction FSM: issue, wait for MemoryUnit to go busy, then idle again
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= M_CPU;
            r_last_grant <= M_AUX;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_WAIT_HI;
                        r_grant <= w_winner;
                    end
                end
                ST_WAIT_HI: begin
                    if (mu_busy) begin
                        r_state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!mu_busy) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Hold the issued command on the bus for the whole transaction;
    // write-enable drops once the transaction retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mu_address <= '0;
            r_mu_data    <= '0;
            r_mu_we      <= 1'b0;
        end else if (w_issue) begin
            r_mu_address <= w_lat_address[w_winner];
            r_mu_data    <= w_lat_data[w_winner];
            r_mu_we      <= w_lat_we[w_winner];
        end else if (w_done) begin
            r_mu_we      <= 1'b0;
        end
    end

    assign mu_start   = w_issue;
    assign mu_address = w_issue ? w_lat_address[w_winner] : r_mu_address;
    assign mu_data    = w_issue ? w_lat_data[w_winner]    : r_mu_data;
    assign mu_we      = w_issue ? w_lat_we[w_winner]      : r_mu_we;

    assign m0_busy = w_pend[M_CPU];
    assign m1_busy = w_pend[M_AUX];
    assign m0_q    = w_q[M_CPU];
    assign m1_q    = w_q[M_AUX];

endmodule
`default_nettype wire

// File: tb/tb_mu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mu_arbiter
// Brief    : Self-checking bench for mu_arbiter. Two instances (round-robin
//            and fixed priority) share master stimulus; each has its own
//            MemoryUnit emulator and transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mu_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              m0_start, m1_start, m0_we, m1_we;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [DATA_W-1:0] m0_data, m1_data;
    logic              mu_init_done;
    logic [1:0]        mu_busy_in;
    logic [DATA_W-1:0] mu_q_in [2];

    logic [1:0]        d_start, d_we, d_m0_busy, d_m1_busy;
    logic [ADDR_W-1:0] d_addr [2];
    logic [DATA_W-1:0] d_data [2];
    logic [DATA_W-1:0] d_m0_q [2];
    logic [DATA_W-1:0] d_m1_q [2];

    mu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
        .m0_busy(d_m0_busy[0]), .m0_q(d_m0_q[0]),
        .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
        .m1_busy(d_m1_busy[0]), .m1_q(d_m1_q[0]),
        .mu_address(d_addr[0]), .mu_data(d_data[0]), .mu_we(d_we[0]), .mu_start(d_start[0]),
        .mu_busy(mu_busy_in[0]), .mu_q(mu_q_in[0]), .mu_init_done(mu_init_done)
    );

    mu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
        .m0_busy(d_m0_busy[1]), .m0_q(d_m0_q[1]),
        .m1_address(m1_address), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
        .m1_busy(d_m1_busy[1]), .m1_q(d_m1_q[1]),
        .mu_address(d_addr[1]), .mu_data(d_data[1]), .mu_we(d_we[1]), .mu_start(d_start[1]),
        .mu_busy(mu_busy_in[1]), .mu_q(mu_q_in[1]), .mu_init_done(mu_init_done)
    );

    // ---------------- reference model (per instance k, master i) ----------
    bit                p_pend [2][2];
    logic [ADDR_W-1:0] p_addr [2][2];
    logic [DATA_W-1:0] p_data [2][2];
    bit                p_we   [2][2];
    logic [DATA_W-1:0] e_q    [2][2];
    int                last_g [2];
    int                owner  [2];      // -1: bus free

    // ---------------- MemoryUnit emulators ---------------------------------
    bit                em_act  [2];
    int                em_hi_s [2], em_hi_e [2], em_done [2];
    logic [DATA_W-1:0] em_rd   [2];
    logic [DATA_W-1:0] mem     [2][1024];
    bit                nx_busy [2];
    logic [DATA_W-1:0] nx_q    [2];
    int                fixed_lat;       // 0: random latency
    logic [ADDR_W:0]   glog0[$], glog1[$];   // {we, address} of each issued op

    int cyc, n_vec, n_fail;

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d] cycle %0d: got 0x%0h, expected 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 2; i++) begin
            p_pend[k][i] = 0; p_addr[k][i] = '0; p_data[k][i] = '0;
            p_we[k][i] = 0;   e_q[k][i] = '0;
        end
        last_g[k] = 1;
        owner[k]  = -1;
        em_act[k] = 0;
    endtask

    // Check one cycle of instance k, then advance model and emulator
    task automatic eval(input int k);
        bit                any, both, issue, o_ok;
        bit                sb [2];
        bit                sw [2];
        logic [ADDR_W-1:0] sa [2];
        logic [DATA_W-1:0] sd [2];
        int                win, o, d, l, nc;
        sb[0] = m0_start; sb[1] = m1_start;
        sw[0] = m0_we;    sw[1] = m1_we;
        sa[0] = m0_address; sa[1] = m1_address;
        sd[0] = m0_data;  sd[1] = m1_data;
        if (reset) model_reset(k);

        any  = p_pend[k][0] || p_pend[k][1];
        both = p_pend[k][0] && p_pend[k][1];
        if (both) win = (k == 1) ? 0 : 1 - last_g[k];
        else      win = p_pend[k][0] ? 0 : 1;
        issue = !reset && owner[k] < 0 && mu_init_done && any;

        chk("mu_start", k, d_start[k], issue);
        o_ok = issue || owner[k] >= 0;
        o = issue ? win : owner[k];
        if (o_ok) begin
            chk("mu_address", k, d_addr[k], p_addr[k][o]);
            chk("mu_data", k, d_data[k], p_data[k][o]);
            chk("mu_we", k, d_we[k], p_we[k][o]);
        end
        chk("m0_busy", k, d_m0_busy[k], p_pend[k][0]);
        chk("m1_busy", k, d_m1_busy[k], p_pend[k][1]);
        chk("m0_q", k, d_m0_q[k], e_q[k][0]);
        chk("m1_q", k, d_m1_q[k], e_q[k][1]);

        // MemoryUnit emulator reacts to what the DUT actually drives
        if (!reset && d_start[k] && !em_act[k]) begin
            d = (fixed_lat > 0) ? 0 : $urandom_range(0, 2);
            l = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
            em_act[k]  = 1;
            em_hi_s[k] = cyc + 1 + d;
            em_hi_e[k] = cyc + d + l;
            em_done[k] = em_hi_e[k] + 1;
            if (d_we[k]) begin
                mem[k][d_addr[k][9:0]] = d_data[k];
                em_rd[k] = $urandom;
            end else begin
                em_rd[k] = mem[k][d_addr[k][9:0]];
            end
            if (k == 0) glog0.push_back({d_we[k], d_addr[k]});
            else        glog1.push_back({d_we[k], d_addr[k]});
        end

        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (sb[i] && !p_pend[k][i]) begin
                    p_pend[k][i] = 1; p_addr[k][i] = sa[i];
                    p_data[k][i] = sd[i]; p_we[k][i] = sw[i];
                end
            end
            o = owner[k];
            if (o >= 0 && em_act[k] && cyc == em_done[k]) begin
                if (!p_we[k][o]) e_q[k][o] = em_rd[k];
                p_pend[k][o] = 0;
                last_g[k]    = o;
                owner[k]     = -1;
            end
            if (issue) owner[k] = win;
        end
        if (em_act[k] && cyc == em_done[k]) em_act[k] = 0;

        nc = cyc + 1;
        nx_busy[k] = em_act[k] && nc >= em_hi_s[k] && nc <= em_hi_e[k];
        nx_q[k]    = (em_act[k] && nc == em_done[k]) ? em_rd[k] : DATA_W'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) eval(k);
        cyc++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mu_busy_in[k] = nx_busy[k];
            mu_q_in[k]    = nx_q[k];
        end
        m0_start = 1'b0;
        m1_start = 1'b0;
    endtask

    function automatic bit busy_any();
        return p_pend[0][0] || p_pend[0][1] || p_pend[1][0] || p_pend[1][1] ||
               owner[0] >= 0 || owner[1] >= 0 || em_act[0] || em_act[1];
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_any() && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) timeout_fail(tag);
        step();
    endtask

    task automatic chk_log(input string name, input int k, input int i, input logic [ADDR_W:0] exp);
        logic [ADDR_W:0] a;
        a = '1;
        if (k == 0 && i < glog0.size()) a = glog0[i];
        if (k == 1 && i < glog1.size()) a = glog1[i];
        chk(name, k, a, exp);
    endtask

    task automatic req(input int m, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dt, input logic w);
        if (m == 0) begin m0_start = 1'b1; m0_address = a; m0_data = dt; m0_we = w; end
        else        begin m1_start = 1'b1; m1_address = a; m1_data = dt; m1_we = w; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; mu_init_done = 1'b1;
        m0_start = 0; m1_start = 0; m0_we = 0; m1_we = 0;
        m0_address = '0; m1_address = '0; m0_data = '0; m1_data = '0;
        mu_busy_in = '0; mu_q_in[0] = '0; mu_q_in[1] = '0;
        cyc = 0; n_vec = 0; n_fail = 0; fixed_lat = 0;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            for (int i = 0; i < 1024; i++) mem[k][i] = 32'hA5A5_0000 | DATA_W'(i);
        end
        @(posedge clk);
        #1;

        // Reset state
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst mu_address", k, d_addr[k], 0);
            chk("rst mu_data", k, d_data[k], 0);
            chk("rst mu_we", k, d_we[k], 0);
            chk("rst mu_start", k, d_start[k], 0);
        end
        reset = 1'b0;
        step();

        // Simultaneous starts, three rounds
        for (int r = 0; r < 3; r++) begin
            req(0, 27'h010 + 27'(r), '0, 1'b0);
            req(1, 27'h020 + 27'(r), '0, 1'b0);
            step();
            wait_idle("simultaneous");
        end
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 3; r++) begin
                chk_log("grant order m0", k, 2 * r,     {1'b0, 27'h010 + 27'(r)});
                chk_log("grant order m1", k, 2 * r + 1, {1'b0, 27'h020 + 27'(r)});
            end
            chk("sim m0_q", k, d_m0_q[k], 32'hA5A5_0012);
            chk("sim m1_q", k, d_m1_q[k], 32'hA5A5_0022);
        end

        // Single read with a 5-cycle busy period
        glog0.delete(); glog1.delete();
        fixed_lat = 5;
        mem[0][10'h100] = 32'hDEAD_BEEF;
        mem[1][10'h100] = 32'hDEAD_BEEF;
        req(0, 27'h100, '0, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("latency m0_busy", k, d_m0_busy[k], 1);
            chk("latency mu_start", k, d_start[k], 1);
            chk("latency mu_address", k, d_addr[k], 27'h100);
        end
        wait_idle("single read");
        fixed_lat = 0;
        for (int k = 0; k < 2; k++) begin
            chk("single m0_q", k, d_m0_q[k], 32'hDEAD_BEEF);
            chk("single m1_q untouched", k, d_m1_q[k], 32'hA5A5_0022);
            chk("single issue count", k, (k == 0) ? glog0.size() : glog1.size(), 1);
        end

        // Tie after a CPU grant: round-robin favours master 1, fixed favours 0
        glog0.delete(); glog1.delete();
        req(0, 27'h030, '0, 1'b0);
        req(1, 27'h040, '0, 1'b0);
        step();
        wait_idle("tie");
        chk_log("rr tie winner", 0, 0, {1'b0, 27'h040});
        chk_log("fixed tie winner", 1, 0, {1'b0, 27'h030});

        // m1 waits while m0 re-requests right after each of its completions
        req(0, 27'h031, '0, 1'b0);
        req(1, 27'h050, '0, 1'b0);
        step();
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (d_m0_busy[1] && n < 200) begin step(); n++; end
            if (n >= 200) timeout_fail("m0 re-request");
            req(0, 27'h032 + 27'(r), '0, 1'b0);
            step();
        end
        wait_idle("fixed priority");

        // Write then read back by master 1
        glog0.delete(); glog1.delete();
        req(1, 27'h200, 32'h1234_5678, 1'b1);
        step();
        wait_idle("write");
        for (int k = 0; k < 2; k++) chk("m1_q after write", k, d_m1_q[k], 32'hA5A5_0050);
        req(1, 27'h200, 32'h0, 1'b0);
        step();
        wait_idle("read back");
        for (int k = 0; k < 2; k++) begin
            chk_log("write op", k, 0, {1'b1, 27'h200});
            chk_log("read op", k, 1, {1'b0, 27'h200});
            chk("m1_q read back", k, d_m1_q[k], 32'h1234_5678);
        end

        // Init gating with a redundant start during the wait
        glog0.delete(); glog1.delete();
        mu_init_done = 1'b0;
        req(0, 27'h060, '0, 1'b0);
        step();
        for (int c = 0; c < 20; c++) begin
            if (c == 8) req(0, 27'h070, '0, 1'b0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            chk("gated issue count", k, (k == 0) ? glog0.size() : glog1.size(), 0);
            chk("gated m0_busy", k, d_m0_busy[k], 1);
        end
        mu_init_done = 1'b1;
        wait_idle("init gating");
        for (int k = 0; k < 2; k++) begin
            chk("ungated issue count", k, (k == 0) ? glog0.size() : glog1.size(), 1);
            chk_log("latched address kept", k, 0, {1'b0, 27'h060});
            chk("gated m0_q", k, d_m0_q[k], 32'hA5A5_0060);
        end

        // Reset during WAIT_LO
        fixed_lat = 5;
        req(0, 27'h080, '0, 1'b0);
        step();
        repeat (3) step();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst mu_start", k, d_start[k], 0);
            chk("midrst mu_we", k, d_we[k], 0);
            chk("midrst mu_address", k, d_addr[k], 0);
            chk("midrst m0_busy", k, d_m0_busy[k], 0);
            chk("midrst m0_q", k, d_m0_q[k], 0);
        end
        step();
        reset = 1'b0;
        step();
        req(0, 27'h090, '0, 1'b0);
        step();
        for (int k = 0; k < 2; k++) chk("post-reset issue", k, d_start[k], 1);
        wait_idle("post reset");
        fixed_lat = 0;
        for (int k = 0; k < 2; k++) chk("post-reset m0_q", k, d_m0_q[k], 32'hA5A5_0090);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            m0_start   = ($urandom_range(0, 3) == 0);
            m1_start   = ($urandom_range(0, 3) == 0);
            m0_address = ADDR_W'($urandom);
            m1_address = ADDR_W'($urandom);
            m0_data    = $urandom;
            m1_data    = $urandom;
            m0_we      = $urandom_range(0, 1) == 1;
            m1_we      = $urandom_range(0, 1) == 1;
            if (mu_init_done) begin
                if ($urandom_range(0, 99) == 0) mu_init_done = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                mu_init_done = 1'b1;
            end
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        mu_init_done = 1'b1;
        wait_idle("random drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mu_arbiter.md
# mu_arbiter

Two-master arbiter sharing the single MemoryUnit bus (address, data, we, start, busy, q) between the CPU (master 0) and a second bus master such as a DMA engine (master 1). It sits between the masters and MemoryUnit. Each master sees an interface with the same start/busy/q protocol as MemoryUnit, so the CPU connects unchanged. Requests are latched, granted by round-robin or fixed priority, and issued one at a time.

## Interface
- ADDR_W, 27, address width (MemoryUnit address space)
- DATA_W, 32, data / q width
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins ties
- clk  in  1  system clock (25 MHz domain)
- reset  in  1  asynchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  request address
- m0_data / m1_data  in  DATA_W  write data
- m0_we / m1_we  in  1  write enable
- m0_start / m1_start  in  1  one-cycle request pulse
- m0_busy / m1_busy  out  1  request outstanding
- m0_q / m1_q  out  DATA_W  read result, registered
- mu_address  out  ADDR_W  to MemoryUnit
- mu_data  out  DATA_W  to MemoryUnit
- mu_we  out  1  to MemoryUnit
- mu_start  out  1  one-cycle pulse to MemoryUnit
- mu_busy  in  1  from MemoryUnit
- mu_q  in  DATA_W  from MemoryUnit
- mu_init_done  in  1  MemoryUnit initDone; no grants are issued while it is low

## Operation
- Per-master request latch. When mN_start=1 and the latch is empty, address, data and we are captured and the pending flag is set. mN_busy goes to 1 on the next edge.
- mN_start while pending is set is ignored. The latch contents do not change.
- FSM states:
  - IDLE: if mu_init_done and any request is pending, select a winner, drive mu_* from the winner's latch and assert mu_start. Go to WAIT_HI.
  - WAIT_HI: mu_start=0. When mu_busy=1, go to WAIT_LO.
  - WAIT_LO: when mu_busy=0, capture mu_q into the winner's mN_q (reads only; writes leave mN_q unchanged). Clear the winner's pending flag and mN_busy, update last_grant, and go to IDLE.
- Arbitration:
  - Round-robin: on a tie, grant the master that is not last_grant. last_grant resets to 1, so master 0 wins the first tie.
  - FIXED_PRIO=1: master 0 wins every tie.
- mu_address, mu_data and mu_we are held stable from the issue cycle until the return to IDLE.
- A master may re-request in the cycle after its mN_busy falls.

## Timing
- Reset values: mu_start=0, mu_we=0, mu_address=0, mu_data=0, m0/m1_busy=0, m0/m1_q=0, state=IDLE, pending flags=0, last_grant=1.
- Latency on an idle bus:
  - mN_start at cycle T: pending is set at T+1 and mu_start pulses at T+1.
  - mN_busy falls one cycle after mu_busy falls, with mN_q valid in that same cycle.
- Back-to-back: a pending loser is issued in the cycle after the winner's completion. Minimum gap between mu_start pulses is 1 idle cycle.
- mN_start in the same cycle as that master's completion is ignored, because pending is still set.
- mu_init_done low: requests latch normally, mN_busy stays high and nothing is issued.
- Reset asserted mid-transaction: all state returns to reset values immediately. The in-flight MemoryUnit operation is abandoned, and MemoryUnit is reset by the same signal.

## Structure
- Package mu_arb_pkg holds:
  - the state enum (IDLE, WAIT_HI, WAIT_LO);
  - master index constants M_CPU=0, M_AUX=1;
  - the default ADDR_W / DATA_W.
- Sub-module mu_arb_req_latch, instantiated once per master. It contains the capture registers, the pending flag, mN_busy and mN_q.
- The top level holds the FSM, arbitration and mu_* output mux/registers.
- Target size: about 200 lines of RTL.

## Test plan
- Single read: m0 read at address 0x0000100. The MemoryUnit model returns 0xDEADBEEF after 5 busy cycles. Expect one mu_start pulse, m0_q=0xDEADBEEF, m0_busy low 1 cycle after mu_busy falls, and m1 untouched.
- Simultaneous start, round-robin: m0 and m1 start in the same cycle, repeated 3 times. Expect grant order 0,1,0,1,0,1 and each master's q matching its own address pattern.
- FIXED_PRIO=1: m1 is pending while m0 re-requests immediately after every completion. Expect m0 to win every tie and m1 to be served only when m0 has nothing pending.
- Write then read: m1 writes 0x12345678 to 0x0000200, then reads it back. Expect mu_we=1 only on the write, m1_q unchanged after the write, and 0x12345678 after the read.
- Init gating and redundant start: hold mu_init_done=0 for 20 cycles with m0 pending, and pulse m0_start again during the wait. Expect no mu_start while mu_init_done is low, exactly one issue once it goes high, and the latched address unchanged.
- Reset mid-operation: assert reset during WAIT_LO. Expect all outputs at reset values immediately and the FSM in IDLE. After release, a new m0 request completes normally.
